gcbp_subimage_extract: RTL
==========================

# gcbp_subimage_extract

Parametrised bit-plane extractor for the stabiliser front end. Consumes the luma pixel stream of one video line and selects one (optionally Gray-coded) bit plane per pixel. Packs the bits falling inside each of N horizontally spaced sub-image windows into one W-bit word per window. Delivers each word over a valid/ready handshake to the sub-image BRAM writer, with per-line bit-plane and Gray-mode selection.

## Interface
Parameters:
- C_SUBIMAGE_WIDTH, 128, bits per sub-image line (window width in pixels)
- C_NUM_SUBIMAGES, 4, horizontal sub-image windows per line
- C_PIXELS_PER_LINE, 720, active pixels per line
- C_EDGE_GAP, 41, pixels between line edge and first/last window
- C_INNER_GAP, 42, pixels between adjacent windows
- C_LUMA_WIDTH, 8, luma sample width

Ports:
- Reset i_resetn, synchronous, active-low; clock i_clk.
- i_clk  in  1  clock
- i_resetn  in  1  synchronous active-low reset
- i_line_start  in  1  one-cycle pulse, next valid beat is pixel 0 of a line
- i_luma_data  in  C_LUMA_WIDTH  pixel sample
- i_luma_data_valid  in  1  sample valid this cycle (may gap arbitrarily)
- i_bit_sel  in  clog2(C_LUMA_WIDTH)  bit plane index, sampled at i_line_start
- i_gray_en  in  1  1 = Gray-code plane, sampled at i_line_start
- o_gcbp_line  out  C_SUBIMAGE_WIDTH  packed sub-image line
- o_gcbp_line_valid  out  1  word held and valid
- i_gcbp_line_ready  in  1  consumer accepts word when valid&ready
- o_subimage_idx  out  clog2(C_NUM_SUBIMAGES)  window index of held word
- o_line_done  out  1  one-cycle pulse after last window word is produced
- o_overflow  out  1  sticky: a completed word was dropped
- o_short_line  out  1  sticky: i_line_start arrived before line completion

## Operation
- Elaboration check: 2*C_EDGE_GAP + N*W + (N-1)*C_INNER_GAP == C_PIXELS_PER_LINE, else $error.
- Plane bit: g = i_gray_en ? (luma ^ (luma>>1)) : luma; bit = g[bit_sel_latched].
- Window k spans pixels [S_k, S_k+W-1], S_k = C_EDGE_GAP + k*(W+C_INNER_GAP).
- Pixel counter p (clog2(C_PIXELS_PER_LINE+1) bits) increments on each valid beat, cleared on i_line_start.
- FSM: IDLE -> (i_line_start) GAP; GAP -> CAPTURE when valid beat has p == S_k; CAPTURE -> GAP after beat p == S_k+W-1 with k < N-1, else -> DONE; DONE -> GAP on i_line_start. i_line_start in any state restarts: p=0, k=0, partial word discarded.
- Capture: shift register shifts left, new bit into LSB; first window pixel ends in bit W-1.
- Valid beats in GAP outside windows and in DONE are ignored. Beats beyond C_PIXELS_PER_LINE are ignored.
- Output holding register: completed word loads if empty or being accepted the same cycle; otherwise word dropped and o_overflow set.
- o_short_line set when i_line_start arrives in GAP/CAPTURE with k>0 or p>0.

## Timing
- Reset: state IDLE, p=0, k=0, shift reg 0, o_gcbp_line=0, o_gcbp_line_valid=0, o_subimage_idx=0, o_line_done=0, o_overflow=0, o_short_line=0.
- Latency: o_gcbp_line_valid rises the cycle after the valid beat carrying pixel S_k+W-1.
- o_gcbp_line/o_subimage_idx stable while valid&!ready; valid drops the cycle after acceptance unless a new word loads simultaneously.
- o_line_done pulses together with valid rising for window N-1.
- i_line_start coincident with a valid beat: beat is pixel 0 of the new line.
- Reset mid-line: all state cleared next edge; no word emitted.

## Structure
- Package gcbp_pkg: state encoding, clog2 function, gray/bit-select function, default geometry constants.
- Sub-module gcbp_out_buf: one-entry valid/ready holding register with overflow detect.

## Test plan
- Default params, gray off, bit 7, luma = 0x80 for p in [41,168], 0 elsewhere -> window 0 word all-ones, windows 1-3 all-zero, idx 0..3, o_line_done with idx 3.
- Gray on, bit 0, luma alternating 0x01/0x02 -> every captured bit 1 (gray 0x01, 0x03).
- Random valid gaps (~50%) with ramp luma -> words identical to gap-free run.
- Hold ready low through windows 0 and 1 -> window 0 word held, window 1 dropped, o_overflow=1.
- i_line_start at p=100 -> o_short_line=1, no window-0 word, next line correct.
- Reset asserted at p=60 -> all outputs reset values next cycle, no valid until new line.

Source files
------------

// File: rtl/gcbp_pkg.sv
// Shared types, default geometry and helper functions for the GCBP sub-image extractor.
package gcbp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_CAPTURE,
        ST_DONE
    } gcbp_state_e;

    localparam int unsigned GCBP_SUBIMAGE_WIDTH  = 128;
    localparam int unsigned GCBP_NUM_SUBIMAGES   = 4;
    localparam int unsigned GCBP_PIXELS_PER_LINE = 720;
    localparam int unsigned GCBP_EDGE_GAP        = 41;
    localparam int unsigned GCBP_INNER_GAP       = 42;
    localparam int unsigned GCBP_LUMA_WIDTH      = 8;

    // Widest luma sample the plane selector handles.
    localparam int unsigned GCBP_MAX_LUMA = 16;
    localparam int unsigned GCBP_SEL_W    = 4;

    // Minimum of one bit so single-entry indices still get a real signal.
    function automatic int unsigned gcbp_clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((64'd1 << r) < 64'(n)) r = r + 1;
        return r;
    endfunction

    function automatic logic plane_bit(
        input logic [GCBP_MAX_LUMA-1:0] luma,
        input logic [GCBP_SEL_W-1:0]    sel,
        input logic                     gray
    );
        logic [GCBP_MAX_LUMA-1:0] g;
        g = gray ? (luma ^ (luma >> 1)) : luma;
        return g[sel];
    endfunction

endpackage

// File: rtl/gcbp_subimage_extract_if.sv
// Valid/ready channel carrying packed sub-image words to the BRAM writer.
interface gcbp_subimage_extract_if
    import gcbp_pkg::*;
#(
    parameter int unsigned C_WIDTH     = GCBP_SUBIMAGE_WIDTH,
    parameter int unsigned C_IDX_WIDTH = gcbp_clog2(GCBP_NUM_SUBIMAGES)
);
    logic [C_WIDTH-1:0]     gcbp_line;
    logic                   gcbp_line_valid;
    logic                   gcbp_line_ready;
    logic [C_IDX_WIDTH-1:0] subimage_idx;

    modport master (
        output gcbp_line,
        output gcbp_line_valid,
        output subimage_idx,
        input  gcbp_line_ready
    );

    modport slave (
        input  gcbp_line,
        input  gcbp_line_valid,
        input  subimage_idx,
        output gcbp_line_ready
    );
endinterface

// File: rtl/gcbp_out_buf.sv
// One-entry holding register for completed sub-image words; flags words it had to drop.
module gcbp_out_buf
    import gcbp_pkg::*;
#(
    parameter int unsigned C_WIDTH     = GCBP_SUBIMAGE_WIDTH,
    parameter int unsigned C_IDX_WIDTH = gcbp_clog2(GCBP_NUM_SUBIMAGES)
) (
    input  logic                   i_clk,
    input  logic                   i_resetn,
    input  logic                   i_load,
    input  logic [C_WIDTH-1:0]     i_word,
    input  logic [C_IDX_WIDTH-1:0] i_idx,
    gcbp_subimage_extract_if.master gcbp_if,
    output logic                   o_overflow
);

    logic [C_WIDTH-1:0]     word_q;
    logic [C_IDX_WIDTH-1:0] idx_q;
    logic                   valid_q;
    logic                   overflow_q;
    logic                   can_load;

    // Loading is allowed while the current word leaves in the same cycle.
    assign can_load = !valid_q || gcbp_if.gcbp_line_ready;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            word_q     <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (i_load && can_load) begin
            word_q  <= i_word;
            idx_q   <= i_idx;
            valid_q <= 1'b1;
        end else begin
            if (valid_q && gcbp_if.gcbp_line_ready) valid_q <= 1'b0;
            if (i_load) overflow_q <= 1'b1;
        end
    end

    assign gcbp_if.gcbp_line       = word_q;
    assign gcbp_if.gcbp_line_valid = valid_q;
    assign gcbp_if.subimage_idx    = idx_q;
    assign o_overflow              = overflow_q;

endmodule

// File: rtl/gcbp_subimage_extract.sv
// Extracts one (optionally Gray-coded) bit plane from a luma line and packs each
// horizontal sub-image window into a single word for the BRAM writer.
module gcbp_subimage_extract
    import gcbp_pkg::*;
#(
    parameter int unsigned C_SUBIMAGE_WIDTH  = GCBP_SUBIMAGE_WIDTH,
    parameter int unsigned C_NUM_SUBIMAGES   = GCBP_NUM_SUBIMAGES,
    parameter int unsigned C_PIXELS_PER_LINE = GCBP_PIXELS_PER_LINE,
    parameter int unsigned C_EDGE_GAP        = GCBP_EDGE_GAP,
    parameter int unsigned C_INNER_GAP       = GCBP_INNER_GAP,
    parameter int unsigned C_LUMA_WIDTH      = GCBP_LUMA_WIDTH
) (
    input  logic                                  i_clk,
    input  logic                                  i_resetn,
    input  logic                                  i_line_start,
    input  logic [C_LUMA_WIDTH-1:0]               i_luma_data,
    input  logic                                  i_luma_data_valid,
    input  logic [gcbp_clog2(C_LUMA_WIDTH)-1:0]   i_bit_sel,
    input  logic                                  i_gray_en,
    gcbp_subimage_extract_if.master               gcbp_if,
    output logic                                  o_line_done,
    output logic                                  o_overflow,
    output logic                                  o_short_line
);

    localparam int unsigned W     = C_SUBIMAGE_WIDTH;
    localparam int unsigned SEL_W = gcbp_clog2(C_LUMA_WIDTH);
    localparam int unsigned IDX_W = gcbp_clog2(C_NUM_SUBIMAGES);
    localparam int unsigned PIX_W = gcbp_clog2(C_PIXELS_PER_LINE + 1);

    localparam logic [PIX_W-1:0] FIRST_START  = PIX_W'(C_EDGE_GAP);
    localparam logic [PIX_W-1:0] WIN_LAST_OFS = PIX_W'(W - 1);
    localparam logic [PIX_W-1:0] WIN_STRIDE   = PIX_W'(W + C_INNER_GAP);
    localparam logic [PIX_W-1:0] PIX_LINE     = PIX_W'(C_PIXELS_PER_LINE);
    localparam logic [IDX_W-1:0] LAST_WIN     = IDX_W'(C_NUM_SUBIMAGES - 1);

    if (2 * C_EDGE_GAP + C_NUM_SUBIMAGES * C_SUBIMAGE_WIDTH
        + (C_NUM_SUBIMAGES - 1) * C_INNER_GAP != C_PIXELS_PER_LINE) begin : g_bad_geometry
        $error("gcbp_subimage_extract: window geometry does not add up to C_PIXELS_PER_LINE");
    end
    if (C_SUBIMAGE_WIDTH < 2 || C_LUMA_WIDTH > GCBP_MAX_LUMA) begin : g_bad_width
        $error("gcbp_subimage_extract: unsupported sub-image or luma width");
    end

    gcbp_state_e      state;
    logic [PIX_W-1:0] pix_cnt;
    logic [IDX_W-1:0] win_idx;
    logic [PIX_W-1:0] win_start;
    logic [W-1:0]     shift_q;
    logic [SEL_W-1:0] bit_sel_q;
    logic             gray_q;
    logic             line_done_q;
    logic             short_line_q;

    gcbp_state_e      cur_state;
    logic [PIX_W-1:0] cur_pix;
    logic [IDX_W-1:0] cur_win;
    logic [PIX_W-1:0] cur_start;
    logic [W-1:0]     cur_shift;
    logic [SEL_W-1:0] cur_sel;
    logic             cur_gray;
    logic             beat;
    logic             in_window;
    logic             win_end;
    logic             plane;
    logic [W-1:0]     next_shift;

    // A line start overrides the registered context so that a coincident beat
    // is processed as pixel 0 of the new line with the newly presented selection.
    always_comb begin
        cur_state  = i_line_start ? ST_GAP      : state;
        cur_pix    = i_line_start ? '0          : pix_cnt;
        cur_win    = i_line_start ? '0          : win_idx;
        cur_start  = i_line_start ? FIRST_START : win_start;
        cur_shift  = i_line_start ? '0          : shift_q;
        cur_sel    = i_line_start ? i_bit_sel   : bit_sel_q;
        cur_gray   = i_line_start ? i_gray_en   : gray_q;
        beat       = i_luma_data_valid && (cur_state != ST_IDLE) && (cur_pix < PIX_LINE);
        in_window  = (cur_state == ST_CAPTURE) || ((cur_state == ST_GAP) && (cur_pix == cur_start));
        win_end    = beat && in_window && (cur_pix == cur_start + WIN_LAST_OFS);
        plane      = plane_bit(GCBP_MAX_LUMA'(i_luma_data), GCBP_SEL_W'(cur_sel), cur_gray);
        next_shift = {cur_shift[W-2:0], plane};
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state        <= ST_IDLE;
            pix_cnt      <= '0;
            win_idx      <= '0;
            win_start    <= FIRST_START;
            shift_q      <= '0;
            bit_sel_q    <= '0;
            gray_q       <= 1'b0;
            line_done_q  <= 1'b0;
            short_line_q <= 1'b0;
        end else begin
            line_done_q <= 1'b0;
            if (i_line_start) begin
                if (((state == ST_GAP) || (state == ST_CAPTURE)) && ((win_idx != '0) || (pix_cnt != '0)))
                    short_line_q <= 1'b1;
                bit_sel_q <= i_bit_sel;
                gray_q    <= i_gray_en;
            end

            state     <= cur_state;
            pix_cnt   <= cur_pix;
            win_idx   <= cur_win;
            win_start <= cur_start;
            shift_q   <= cur_shift;

            if (beat) begin
                pix_cnt <= cur_pix + 1'b1;
                if (in_window) begin
                    if (win_end) begin
                        shift_q <= '0;
                        if (cur_win == LAST_WIN) begin
                            state       <= ST_DONE;
                            line_done_q <= 1'b1;
                        end else begin
                            state     <= ST_GAP;
                            win_idx   <= cur_win + 1'b1;
                            win_start <= cur_start + WIN_STRIDE;
                        end
                    end else begin
                        state   <= ST_CAPTURE;
                        shift_q <= next_shift;
                    end
                end
            end
        end
    end

    gcbp_out_buf #(
        .C_WIDTH     (W),
        .C_IDX_WIDTH (IDX_W)
    ) u_out_buf (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .i_load     (win_end),
        .i_word     (next_shift),
        .i_idx      (cur_win),
        .gcbp_if    (gcbp_if),
        .o_overflow (o_overflow)
    );

    assign o_line_done  = line_done_q;
    assign o_short_line = short_line_q;

endmodule
